div_sequencer: RTL and testbench

Sequencer and 2-way arbiter that shares the single 4-bit restoring divider (`divisor`) between two requesters in the ALU. It accepts operand pairs over valid/ready, grants round-robin, drives the divider's `init`/operand inputs with the required hold timing, waits for `done`, and returns quotient plus error status over a valid/ready response port. Sits between the ALU op decoder and the divider instance.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/div_sequencer_rr_arb2.sv | 15 +
 rtl/div_sequencer.sv | 136 +++++++++++++
 tb/tb_div_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU divider sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_RESP
    } seq_state_t;

    localparam logic [3:0] ERR_Q = 4'hE;
    localparam logic [3:0] TMO_Q = 4'hF;

    localparam int unsigned DEF_FLUSH_CYC = 64;
    localparam int unsigned DEF_TIMEOUT   = 48;

endpackage

// File: rtl/div_sequencer_rr_arb2.sv
// Combinational 2-way round-robin grant; the requester other than `last` wins a tie.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = valid0 & (~valid1 | last);
        grant1 = valid1 & (~valid0 | ~last);
    end

endmodule

// File: rtl/div_sequencer.sv
// Shares one restoring divider between two requesters with round-robin grant.
// Optional WAIT-state watchdog compiled in with DIV_TIMEOUT_EN.
module div_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned FLUSH_CYC = DEF_FLUSH_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_q,
    output logic       rsp_err,
    input  logic       rsp_ready,
    output logic       div_init,
    output logic [3:0] div_dividend,
    output logic [3:0] div_divisor,
    input  logic       div_done,
    input  logic [3:0] div_q,
    output logic       busy
);

    localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [FW-1:0] flush_cnt;
    logic          flush_done;
    logic          last;
    logic          grant0;
    logic          grant1;
    logic          take;
    logic          wd_expired;
    logic          tmo_flag;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (last),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign take       = grant0 | grant1;
    assign flush_done = (flush_cnt == FW'(FLUSH_CYC - 1));

`ifdef DIV_TIMEOUT_EN
    logic [5:0] wd_cnt;

    assign wd_expired = (state == S_WAIT) && !div_done && (wd_cnt == 6'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt   <= '0;
            tmo_flag <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 6'd1 : '0;
            if (wd_expired)
                tmo_flag <= 1'b1;
            else if (state == S_RESP && rsp_ready)
                tmo_flag <= 1'b0;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign tmo_flag   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FLUSH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FLUSH: if (flush_done) state_nxt = S_IDLE;
            S_IDLE:  if (take) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_ARM;
            S_ARM:   state_nxt = S_WAIT;
            S_WAIT:  if (div_done || wd_expired) state_nxt = S_RESP;
            // a timed-out divide may still be running, so drain it before the next grant
            S_RESP:  if (rsp_ready) state_nxt = tmo_flag ? S_FLUSH : S_IDLE;
            default: state_nxt = S_FLUSH;
        endcase
    end

    always_comb begin
        req0_ready = (state == S_IDLE) & grant0;
        req1_ready = (state == S_IDLE) & grant1;
        div_init   = (state == S_ISSUE);
        rsp_valid  = (state == S_RESP);
        busy       = (state != S_IDLE) & ~reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt    <= '0;
            last         <= 1'b1;
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_id       <= 1'b0;
            rsp_q        <= '0;
            rsp_err      <= 1'b0;
        end else begin
            flush_cnt <= (state == S_FLUSH && !flush_done) ? flush_cnt + FW'(1) : '0;
            if (state == S_IDLE && take) begin
                div_dividend <= grant1 ? req1_a : req0_a;
                div_divisor  <= grant1 ? req1_b : req0_b;
                rsp_id       <= grant1;
                last         <= grant1;
            end
            if (state == S_WAIT) begin
                if (div_done) begin
                    rsp_q   <= div_q;
                    rsp_err <= (div_divisor == 4'd0);
                end else if (wd_expired) begin
                    rsp_q   <= TMO_Q;
                    rsp_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural divider model (no reset, stale done).
module tb_div_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_a = '0;
    logic [3:0] req0_b = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_a = '0;
    logic [3:0] req1_b = '0;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_id;
    logic [3:0] rsp_q;
    logic       rsp_err;
    logic       rsp_ready = 1'b0;
    logic       div_init;
    logic [3:0] div_dividend;
    logic [3:0] div_divisor;
    logic       div_done = 1'b0;
    logic [3:0] div_q = '0;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_sequencer #(.TIMEOUT(48), .FLUSH_CYC(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_ready   (req1_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_q        (rsp_q),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready),
        .div_init     (div_init),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_q        (div_q),
        .busy         (busy)
    );

    // divider model: starts on a sampled init, done stays high until the next init
    logic       m_hang = 1'b0;
    logic       m_busy = 1'b0;
    logic [3:0] m_res = '0;
    int         m_cnt = 0;

    always @(posedge clk) begin
        if (div_init) begin
            m_busy   <= 1'b1;
            div_done <= 1'b0;
            div_q    <= 4'h9;
            m_res    <= (div_divisor == 4'd0) ? 4'hE : div_dividend / div_divisor;
            m_cnt    <= (div_divisor == 4'd0) ? 2 * 14 + 4
                                              : 2 * int'(div_dividend / div_divisor) + 4;
        end else if (m_busy && !m_hang) begin
            if (m_cnt <= 1) begin
                m_busy   <= 1'b0;
                div_done <= 1'b1;
                div_q    <= m_res;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {13'b0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_err,
                div_init, div_dividend, div_divisor, busy};
    endfunction

    // raise a request, wait for its grant, check the latched operands and the init pulse
    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b, input string tag);
        int n;
        if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        n = 0;
        while (!((id == 0) ? req0_ready : req1_ready) && n < 200) begin tick; n++; end
        chk({tag, "_grant"}, 32'(n < 200), 1);
        tick;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk({tag, "_init_hi"}, {31'b0, div_init}, 1);
        chk({tag, "_ops"}, {24'b0, div_dividend, div_divisor}, {24'b0, a, b});
        chk({tag, "_id"}, {31'b0, rsp_id}, 32'(id));
        tick;
        chk({tag, "_init_lo"}, {30'b0, div_init, req0_ready | req1_ready}, 0);
    endtask

    task automatic collect(input int id, input logic [3:0] q, input logic err,
                           input logic [3:0] a, input logic [3:0] b,
                           input int stall, input string tag);
        int n;
        int viol;
        n = 0;
        while (!rsp_valid && n < 100) begin tick; n++; end
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 1);
        chk({tag, "_rsp"}, {26'b0, rsp_id, rsp_q, rsp_err}, {26'b0, 1'(id), q, err});
        viol = 0;
        for (int i = 0; i < stall; i++) begin
            tick;
            if ({rsp_valid, rsp_id, rsp_q, rsp_err} !== {1'b1, 1'(id), q, err}) viol++;
            if ({div_dividend, div_divisor} !== {a, b}) viol++;
            if (req0_ready || req1_ready || div_init) viol++;
        end
        if (stall > 0) chk({tag, "_stall_viol"}, 32'(viol), 0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk({tag, "_after"}, {30'b0, rsp_valid, busy}, 0);
    endtask

    initial begin
        int viol;
        int n;

        // reset with req0 already pending, then the flush window
        req0_valid = 1'b1; req0_a = 4'd13; req0_b = 4'd4;
        repeat (3) tick;
        chk("reset_outs", outs(), 0);
        reset = 1'b0;
        #1;
        chk("flush_busy", {31'b0, busy}, 1);
        viol = (req0_ready || req1_ready) ? 1 : 0;
        for (int i = 1; i < 64; i++) begin
            tick;
            if (req0_ready || req1_ready) viol++;
        end
        chk("flush_ready_low", 32'(viol), 0);
        tick;
        chk("flush_grant", {30'b0, req0_ready, req1_ready}, 32'b10);

        issue(0, 4'd13, 4'd4, "single");
        collect(0, 4'd3, 1'b0, 4'd13, 4'd4, 0, "single");

        issue(1, 4'd7, 4'd0, "dz");
        collect(1, 4'hE, 1'b1, 4'd7, 4'd0, 0, "dz");

        // both requesters held valid: grants must alternate 0,1,0,1
        req0_valid = 1'b1; req0_a = 4'd9;  req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd5;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 200) begin tick; n++; end
            chk("cont_excl", {31'b0, req0_ready & req1_ready}, 0);
            chk("cont_grant", {30'b0, req0_ready, req1_ready}, (k % 2 == 0) ? 32'b10 : 32'b01);
            tick;
            chk("cont_id", {31'b0, rsp_id}, 32'(k % 2));
            collect(k % 2, 4'd3, 1'b0, (k % 2 == 0) ? 4'd9 : 4'd15,
                    (k % 2 == 0) ? 4'd3 : 4'd5, 0, "cont");
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // back-pressure with a competing request pending
        issue(0, 4'd10, 4'd2, "bp");
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
        collect(0, 4'd5, 1'b0, 4'd10, 4'd2, 10, "bp");
        req1_valid = 1'b0;

        issue(1, 4'd15, 4'd1, "worst");
        collect(1, 4'd15, 1'b0, 4'd15, 4'd1, 0, "worst");

`ifdef DIV_TIMEOUT_EN
        m_hang = 1'b1;
        issue(0, 4'd6, 4'd2, "wd");
        n = 0;
        while (!rsp_valid && n < 100) begin tick; n++; end
        chk("wd_latency", 32'(n), 49);
        chk("wd_rsp", {26'b0, rsp_id, rsp_q, rsp_err}, {26'b0, 1'b0, 4'hF, 1'b1});
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("wd_to_flush", {29'b0, rsp_valid, busy, req0_ready}, 32'b010);
        m_hang = 1'b0;
`endif

        // reset mid-WAIT clears every output at once
        issue(1, 4'd15, 4'd1, "rst");
        repeat (5) tick;
        chk("rst_wait_busy", {31'b0, busy}, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_outs", outs(), 0);
        tick;
        chk("rst_hold_outs", outs(), 0);
        reset = 1'b0;
        tick;
        chk("rst_flush", {29'b0, busy, rsp_valid, req1_ready}, 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
